// File: rtl/cdb_broadcaster_pkg.sv
// Shared definitions for the CDB broadcaster: FU source indices, tag constants,
// arbitration mode and a small popcount helper.
package cdb_broadcaster_pkg;

  localparam int unsigned FU_ALU  = 0;
  localparam int unsigned FU_MEM  = 1;
  localparam int unsigned FU_MUL  = 2;
  localparam int unsigned FU_DIV  = 3;
  localparam int unsigned FU_JUMP = 4;

  localparam int unsigned CDB_N_SRC = 5;
  localparam int unsigned CDB_TAGW  = 8;
  localparam int unsigned CDB_DW    = 32;
  localparam int unsigned CDB_PCW   = 32;

  // Tag 0 marks "no broadcast" on the bus.
  localparam logic [CDB_TAGW-1:0] CDB_NONE = '0;

  localparam logic [15:0] CONFLICT_MAX = '1;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      n += 32'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Result-source handshake and CDB broadcast bundle. master = FU/consumer side,
// slave = the broadcaster.
interface cdb_broadcaster_if #(
  parameter int unsigned N_SRC = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned TAGW  = 8
);
  logic [N_SRC-1:0]      src_valid;
  logic [N_SRC-1:0]      src_ready;
  logic [N_SRC*TAGW-1:0] src_tag;
  logic [N_SRC*DW-1:0]   src_data;
  logic [N_SRC*32-1:0]   src_pc;

  logic                  cdb_valid;
  logic [TAGW-1:0]       cdb_tag;
  logic [DW-1:0]         cdb_data;
  logic [31:0]           cdb_pc;

  modport master (
    output src_valid, src_tag, src_data, src_pc,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_pc
  );

  modport slave (
    input  src_valid, src_tag, src_data, src_pc,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_pc
  );
endinterface

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// One-hot request arbiter, fixed-priority (lowest index) or round-robin.
// Owns its rotation pointer so it can be reused by the RS issue select.
module rr_arbiter
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant
);

  localparam int unsigned PW   = (N > 1) ? $clog2(N) : 1;
  localparam arb_mode_e   MODE = (RR != 0) ? ARB_RR : ARB_FIXED;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx, gidx;
  logic          found;
  int unsigned   start;

  // Scan starts at the pointer in RR mode, at 0 in fixed mode; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    start = (MODE == ARB_RR) ? 32'(ptr_q) : 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((start + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (adv && found) begin
      ptr_d = PW'((32'(gidx) + 32'd1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: one result slot per FU, arbitrated down to a single
// registered (tag, data, pc) broadcast per cycle.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned N_SRC = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned TAGW  = 8,
  parameter int unsigned RR    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  cdb_broadcaster_if.slave       bus,
  output logic [N_SRC-1:0]       pending,
  output logic [15:0]            conflict_cnt,
  output logic                   tag0_err
);

  logic [N_SRC-1:0]      pend_q, pend_d;
  logic [N_SRC-1:0]      grant, ready, accept, capture;
  logic [N_SRC*TAGW-1:0] slot_tag;
  logic [N_SRC*DW-1:0]   slot_data;
  logic [N_SRC*32-1:0]   slot_pc;

  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAGW-1:0]       cdb_tag_q, cdb_tag_d;
  logic [DW-1:0]         cdb_data_q, cdb_data_d;
  logic [31:0]           cdb_pc_q, cdb_pc_d;
  logic [15:0]           conflict_q, conflict_d;
  logic                  tag0_q, tag0_d;
  logic                  multi_pend;

  rr_arbiter #(
    .N  (N_SRC),
    .RR (RR)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (pend_q),
    .adv   (1'b1),
    .grant (grant)
  );

  // A slot being drained this edge can take a new result on the same edge.
  for (genvar g = 0; g < N_SRC; g++) begin : g_slot
    logic [TAGW-1:0] tag_q;
    logic [DW-1:0]   data_q;
    logic [31:0]     pc_q;

    assign ready[g]   = ~pend_q[g] | grant[g];
    assign accept[g]  = bus.src_valid[g] & ready[g];
    assign capture[g] = accept[g] &
                        (bus.src_tag[g*TAGW +: TAGW] != TAGW'(CDB_NONE));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tag_q  <= '0;
        data_q <= '0;
        pc_q   <= '0;
      end else if (capture[g]) begin
        tag_q  <= bus.src_tag[g*TAGW +: TAGW];
        data_q <= bus.src_data[g*DW +: DW];
        pc_q   <= bus.src_pc[g*32 +: 32];
      end
    end

    assign slot_tag[g*TAGW +: TAGW] = tag_q;
    assign slot_data[g*DW +: DW]    = data_q;
    assign slot_pc[g*32 +: 32]      = pc_q;
  end

  always_comb begin
    pend_d      = capture | (pend_q & ~grant);
    cdb_valid_d = |grant;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    cdb_pc_d    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        cdb_tag_d  = cdb_tag_d  | slot_tag[i*TAGW +: TAGW];
        cdb_data_d = cdb_data_d | slot_data[i*DW +: DW];
        cdb_pc_d   = cdb_pc_d   | slot_pc[i*32 +: 32];
      end
    end
    multi_pend = popcount32(32'(pend_q)) >= 32'd2;
    conflict_d = conflict_q;
    if (multi_pend && (conflict_q != CONFLICT_MAX)) begin
      conflict_d = conflict_q + 16'd1;
    end
    tag0_d = tag0_q | (|(accept & ~capture));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_pc_q    <= '0;
      conflict_q  <= '0;
      tag0_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_pc_q    <= cdb_pc_d;
      conflict_q  <= conflict_d;
      tag0_q      <= tag0_d;
    end
  end

  assign bus.src_ready = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_pc    = cdb_pc_q;
  assign pending       = pend_q;
  assign conflict_cnt  = conflict_q;
  assign tag0_err      = tag0_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: a fixed-priority instance and a
// round-robin instance, all expectations hand-computed.
module tb_cdb_broadcaster;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_broadcaster_if #(.N_SRC(5), .DW(32), .TAGW(8)) bus0 ();
  cdb_broadcaster_if #(.N_SRC(5), .DW(32), .TAGW(8)) bus1 ();

  logic [4:0]  pending0, pending1;
  logic [15:0] conflict0, conflict1;
  logic        tag0err0, tag0err1;

  cdb_broadcaster #(.N_SRC(5), .DW(32), .TAGW(8), .RR(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .pending(pending0), .conflict_cnt(conflict0), .tag0_err(tag0err0)
  );

  cdb_broadcaster #(.N_SRC(5), .DW(32), .TAGW(8), .RR(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .pending(pending1), .conflict_cnt(conflict1), .tag0_err(tag0err1)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data and PC are derived from the tag so checks can be written from the tag alone.
  task automatic offer(input bit which, input int unsigned idx, input logic [7:0] t);
    if (!which) begin
      bus0.src_valid[idx]         = 1'b1;
      bus0.src_tag[idx*8 +: 8]    = t;
      bus0.src_data[idx*32 +: 32] = 32'hD000_0000 | 32'(t);
      bus0.src_pc[idx*32 +: 32]   = 32'h0000_1000 + 32'(t);
    end else begin
      bus1.src_valid[idx]         = 1'b1;
      bus1.src_tag[idx*8 +: 8]    = t;
      bus1.src_data[idx*32 +: 32] = 32'hD000_0000 | 32'(t);
      bus1.src_pc[idx*32 +: 32]   = 32'h0000_1000 + 32'(t);
    end
  endtask

  task automatic clear_all();
    bus0.src_valid = '0;
    bus1.src_valid = '0;
  endtask

  int unsigned nb, div_pos, low_run;
  logic        alu_low2;

  initial begin
    bus0.src_valid = '0; bus0.src_tag = '0; bus0.src_data = '0; bus0.src_pc = '0;
    bus1.src_valid = '0; bus1.src_tag = '0; bus1.src_data = '0; bus1.src_pc = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    check("rst_valid",    64'(bus0.cdb_valid), 64'd0);
    check("rst_pending",  64'(pending0), 64'd0);
    check("rst_ready",    64'(bus0.src_ready), 64'h1F);
    check("rst_conflict", 64'(conflict0), 64'd0);
    check("rst_tag0",     64'(tag0err0), 64'd0);

    // Mid-run reset with pend=10110 and an ALU broadcast in flight
    offer(0, 0, 8'h31);
    tick();
    clear_all();
    offer(0, 1, 8'h32); offer(0, 2, 8'h33); offer(0, 4, 8'h34);
    tick();
    clear_all();
    check("mid_pending", 64'(pending0), 64'h16);
    check("mid_valid",   64'(bus0.cdb_valid), 64'd1);
    check("mid_tag",     64'(bus0.cdb_tag), 64'h31);
    #2 rst = 1'b0;
    #1;
    check("arst_valid",   64'(bus0.cdb_valid), 64'd0);
    check("arst_tag",     64'(bus0.cdb_tag), 64'd0);
    check("arst_pending", 64'(pending0), 64'd0);
    check("arst_ready",   64'(bus0.src_ready), 64'h1F);
    @(posedge clk);
    #1 rst = 1'b1;

    // Tag 0 is accepted and dropped; then a 2-deep conflict
    offer(0, 2, 8'h00);
    check("t0_ready", 64'(bus0.src_ready[2]), 64'd1);
    tick();
    clear_all();
    check("t0_err",     64'(tag0err0), 64'd1);
    check("t0_pending", 64'(pending0), 64'd0);
    tick();
    check("t0_nobcast", 64'(bus0.cdb_valid), 64'd0);
    offer(0, 0, 8'h11); offer(0, 1, 8'h12);
    tick();
    clear_all();
    check("cf_pending", 64'(pending0), 64'h03);
    check("cf_cnt0",    64'(conflict0), 64'd0);
    tick();
    check("cf_tag_a",   64'(bus0.cdb_tag), 64'h11);
    check("cf_cnt1",    64'(conflict0), 64'd1);
    tick();
    check("cf_tag_b",   64'(bus0.cdb_tag), 64'h12);
    check("cf_cnt1b",   64'(conflict0), 64'd1);
    tick();
    check("cf_idle",    64'(bus0.cdb_valid), 64'd0);

    // Single ALU result: visible two cycles after acceptance, for one cycle
    offer(0, 0, 8'h01);
    bus0.src_data[31:0] = 32'h0000_1234;
    tick();
    clear_all();
    check("s_c1_valid", 64'(bus0.cdb_valid), 64'd0);
    tick();
    check("s_c2_valid", 64'(bus0.cdb_valid), 64'd1);
    check("s_c2_tag",   64'(bus0.cdb_tag), 64'h01);
    check("s_c2_data",  64'(bus0.cdb_data), 64'h1234);
    check("s_c2_pc",    64'(bus0.cdb_pc), 64'h1001);
    tick();
    check("s_c3_valid", 64'(bus0.cdb_valid), 64'd0);
    check("s_c3_data",  64'(bus0.cdb_data), 64'd0);

    // All five at once, fixed priority: tags 1..5 on consecutive cycles
    for (int unsigned i = 0; i < 5; i++) offer(0, i, 8'(i + 1));
    tick();
    clear_all();
    check("all_pending", 64'(pending0), 64'h1F);
    check("all_ready",   64'(bus0.src_ready), 64'h01);
    check("all_c1",      64'(bus0.cdb_valid), 64'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check("all_valid", 64'(bus0.cdb_valid), 64'd1);
      check("all_tag",   64'(bus0.cdb_tag), 64'(i + 1));
      check("all_data",  64'(bus0.cdb_data), 64'(32'hD000_0000 + i + 1));
    end
    tick();
    check("all_done",     64'(bus0.cdb_valid), 64'd0);
    check("all_conflict", 64'(conflict0), 64'd5);

    // Same-slot refill on MEM while its old entry is granted
    offer(0, 1, 8'h04);
    tick();
    offer(0, 1, 8'h05);
    check("rf_ready", 64'(bus0.src_ready[1]), 64'd1);
    tick();
    clear_all();
    check("rf_tag4",    64'(bus0.cdb_tag), 64'h04);
    check("rf_pend",    64'(pending0), 64'h02);
    tick();
    check("rf_tag5",    64'(bus0.cdb_tag), 64'h05);
    check("rf_pend0",   64'(pending0), 64'h00);
    tick();
    check("rf_idle",    64'(bus0.cdb_valid), 64'd0);

    // Round-robin: ALU floods, DIV offered once, must not starve
    nb = 0; div_pos = 0; low_run = 0; alu_low2 = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      offer(1, 0, 8'h21);
      if (k == 2) begin
        offer(1, 3, 8'h44);
        check("rr_div_rdy", 64'(bus1.src_ready[3]), 64'd1);
      end else begin
        bus1.src_valid[3] = 1'b0;
      end
      if (!bus1.src_ready[0]) begin
        low_run++;
        if (low_run >= 2) alu_low2 = 1'b1;
      end else begin
        low_run = 0;
      end
      tick();
      if (k >= 2 && bus1.cdb_valid) begin
        nb++;
        if (bus1.cdb_tag == 8'h44 && div_pos == 0) div_pos = nb;
      end
    end
    clear_all();
    check("rr_div_pos",   64'(div_pos), 64'd2);
    check("rr_alu_low2",  64'(alu_low2), 64'd0);
    check("rr0_tag0_err", 64'(tag0err0), 64'd1);

    rst = 1'b0;
    #1;
    check("end_tag0",     64'(tag0err0), 64'd0);
    check("end_conflict", 64'(conflict0), 64'd0);
    check("end_pend1",    64'(pending1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
